// File: rtl/design_select_ctrl.sv
// Design-select sequencer: synchronises and debounces the raw select pins, then switches
// the active design by gating GPIOs, holding every design in reset and releasing only the new one.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | steady; active design owns the GPIOs (gated when none selected)
// GATE    | GPIOs gated, old design still running, waiting GATE_CYCLES
// HOLD    | every design in reset for RST_CYCLES, target already latched
// RELEASE | new design out of reset, GPIOs still gated for one cycle
module design_select_ctrl #(
    parameter int NUM_DESIGNS     = 15,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 2,
    parameter int RST_CYCLES      = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [3:0]             sel_pin,
    output logic [3:0]             active_sel,
    output logic [NUM_DESIGNS-1:0] design_rst_n,
    output logic                   gpio_gate,
    output logic                   busy
);

    localparam int CNT_MAX = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        GATE    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic [3:0]               active_next;
    logic [NUM_DESIGNS-1:0]   rst_n_next;
    logic                     gate_next;
    logic                     busy_next;

    logic [3:0]               sync_meta;
    logic [3:0]               sync_q;
    logic [3:0]               sync_sel;
    logic [3:0]               prev_sel;
    logic [3:0]               stable_sel;
    logic [DB_W-1:0]          db_cnt, db_cnt_next;
    logic                     db_accept;
    logic [NUM_DESIGNS-1:0]   sel_onehot;

    // Codes above the number of fitted designs behave as a deselect.
    assign sync_sel = (sync_q > 4'(NUM_DESIGNS)) ? 4'd0 : sync_q;

    always_comb begin
        db_cnt_next = db_cnt;
        if (sync_sel != prev_sel) begin
            db_cnt_next = '0;
        end else if (db_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
            db_cnt_next = db_cnt + DB_W'(1);
        end
    end

    assign db_accept = (db_cnt_next == DB_W'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta  <= '0;
            sync_q     <= '0;
            prev_sel   <= '0;
            db_cnt     <= '0;
            stable_sel <= '0;
        end else begin
            sync_meta <= sel_pin;
            sync_q    <= sync_meta;
            prev_sel  <= sync_sel;
            db_cnt    <= db_cnt_next;
            if (db_accept) begin
                stable_sel <= sync_sel;
            end
        end
    end

    // Code 0 decodes to no bit set, so a deselect keeps every design in reset.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            if (active_sel == 4'(i + 1)) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        active_next = active_sel;
        rst_n_next  = design_rst_n;
        gate_next   = gpio_gate;
        busy_next   = busy;
        case (state)
            RUN: begin
                gate_next = (active_sel == 4'd0);
                busy_next = 1'b0;
                if (stable_sel != active_sel) begin
                    state_next = GATE;
                    cnt_next   = CNT_W'(GATE_CYCLES - 1);
                    gate_next  = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    state_next  = HOLD;
                    rst_n_next  = '0;
                    active_next = stable_sel;
                    cnt_next    = CNT_W'(RST_CYCLES - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = RELEASE;
                    rst_n_next = sel_onehot;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RELEASE: begin
                state_next = RUN;
                busy_next  = 1'b0;
                gate_next  = (active_sel == 4'd0);
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= RUN;
            cnt          <= '0;
            active_sel   <= '0;
            design_rst_n <= '0;
            gpio_gate    <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            active_sel   <= active_next;
            design_rst_n <= rst_n_next;
            gpio_gate    <= gate_next;
            busy         <= busy_next;
        end
    end

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed bench for design_select_ctrl with ten designs fitted so that codes 11..15 are
// out of range; expectations are hand-derived switchover timings and reset patterns.
module tb_design_select_ctrl;

    logic       clk;
    logic       n_rst;
    logic [3:0] sel_pin;
    logic [3:0] active_sel;
    logic [9:0] design_rst_n;
    logic       gpio_gate;
    logic       busy;

    int vectors;
    int miscompares;
    int idle;

    design_select_ctrl #(
        .NUM_DESIGNS     (10),
        .DEBOUNCE_CYCLES (4),
        .GATE_CYCLES     (2),
        .RST_CYCLES      (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sel_pin      (sel_pin),
        .active_sel   (active_sel),
        .design_rst_n (design_rst_n),
        .gpio_gate    (gpio_gate),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for busy, then follows the switchover to its end and checks it.
    task automatic run_seq(input string tag, input logic [3:0] exp_code, input logic [9:0] exp_rst,
                           input logic exp_gate, input logic chg, input logic [3:0] chg_pin,
                           output int wait_cycles);
        int         t;
        int         n;
        logic [9:0] last_rst;
        logic       last_gate;
        t = 0;
        while (busy !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        wait_cycles = t;
        check({tag, "_busy_rise"}, 16'(busy), 16'd1);
        if (chg) sel_pin = chg_pin;
        n = 0;
        last_rst = '0;
        last_gate = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 0) check({tag, "_gate_in_gate"}, 16'(gpio_gate), 16'd1);
            if (n == 2) check({tag, "_hold_rst"}, 16'(design_rst_n), 16'd0);
            last_rst = design_rst_n;
            last_gate = gpio_gate;
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_len"}, 16'(n), 16'd7);
        check({tag, "_release_rst"}, 16'(last_rst), 16'(exp_rst));
        check({tag, "_release_gate"}, 16'(last_gate), 16'd1);
        check({tag, "_active"}, 16'(active_sel), 16'(exp_code));
        check({tag, "_run_gate"}, 16'(gpio_gate), 16'(exp_gate));
        check({tag, "_run_rst"}, 16'(design_rst_n), 16'(exp_rst));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n_rst = 1'b1;
        sel_pin = 4'd5;

        // Asynchronous reset, sampled between clock edges.
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("rst_active", 16'(active_sel), 16'd0);
        check("rst_design_rst", 16'(design_rst_n), 16'd0);
        check("rst_gate", 16'(gpio_gate), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        sel_pin = 4'd0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_hold", {active_sel, design_rst_n, gpio_gate, busy},
                  {4'd0, 10'h000, 1'b1, 1'b0});
        end

        // Plain select of design 3.
        sel_pin = 4'd3;
        run_seq("sel3", 4'd3, 10'h004, 1'b0, 1'b0, 4'd0, idle);

        // Short glitch is filtered.
        sel_pin = 4'd7;
        repeat (3) @(negedge clk);
        sel_pin = 4'd3;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("glitch3", {active_sel, design_rst_n, gpio_gate, busy},
                  {4'd3, 10'h004, 1'b0, 1'b0});
        end

        // Six-cycle pulse is accepted, then the return to 3 follows after one RUN cycle.
        sel_pin = 4'd7;
        repeat (6) @(negedge clk);
        sel_pin = 4'd3;
        run_seq("pulse7", 4'd7, 10'h040, 1'b0, 1'b0, 4'd0, idle);
        run_seq("back3", 4'd3, 10'h004, 1'b0, 1'b0, 4'd0, idle);
        check("back3_run_len", 16'(idle), 16'd1);

        // Change of select while the first switchover is in flight.
        sel_pin = 4'd9;
        run_seq("sel9", 4'd9, 10'h100, 1'b0, 1'b1, 4'd2, idle);
        run_seq("sel2", 4'd2, 10'h002, 1'b0, 1'b0, 4'd0, idle);
        check("sel2_run_len", 16'(idle), 16'd1);

        // Out-of-range code deselects.
        sel_pin = 4'd4;
        run_seq("sel4", 4'd4, 10'h008, 1'b0, 1'b0, 4'd0, idle);
        sel_pin = 4'd12;
        run_seq("oor12", 4'd0, 10'h000, 1'b1, 1'b0, 4'd0, idle);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("oor_idle", {active_sel, design_rst_n, gpio_gate, busy},
                  {4'd0, 10'h000, 1'b1, 1'b0});
        end

        // Reset while in GATE aborts the switchover.
        sel_pin = 4'd5;
        idle = 0;
        while (busy !== 1'b1 && idle < 40) begin
            @(negedge clk);
            idle++;
        end
        check("abort_busy_rise", 16'(busy), 16'd1);
        #2 n_rst = 1'b0;
        #1;
        check("abort_rst", {active_sel, design_rst_n, gpio_gate, busy},
              {4'd0, 10'h000, 1'b1, 1'b0});
        @(negedge clk);
        sel_pin = 4'd0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_idle", {active_sel, design_rst_n, gpio_gate, busy},
                  {4'd0, 10'h000, 1'b1, 1'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
